// File: rtl/apb_bridge_mux.sv
// AHB-side request to APB bridge: decodes NSLV equal regions above BASE and runs SETUP/ACCESS transfers.
// Optional ACCESS-phase watchdog is built when APB_TIMEOUT_EN is defined.
module apb_bridge_mux #(
    parameter int unsigned     AW      = 32,
    parameter int unsigned     DW      = 32,
    parameter int unsigned     NSLV    = 2,
    parameter logic [AW-1:0]   BASE    = AW'(32'hA000_0800),
    parameter logic [AW-1:0]   REGION  = AW'(32'h200),
    parameter int unsigned     TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bridge_enable,
    input  logic [AW-1:0]      haddr,
    input  logic               hwrite,
    input  logic [DW-1:0]      hwdata,
    output logic               hready_out,
    output logic [DW-1:0]      hrdata,
    output logic               hresp,
    output logic [AW-1:0]      paddr,
    output logic               pwrite,
    output logic [DW-1:0]      pwdata,
    output logic [NSLV-1:0]    psel,
    output logic               penable,
    input  logic [NSLV*DW-1:0] prdata,
    input  logic [NSLV-1:0]    pready,
    input  logic [NSLV-1:0]    pslverr
);

    localparam int unsigned   IW       = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned   RSH      = $clog2(REGION);
    localparam logic [AW-1:0] SPAN     = AW'(NSLV) * REGION;
    localparam logic [AW-1:0] OFF_MASK = REGION - AW'(1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   sel_q, sel_nxt;
    logic            hready_nxt, hresp_nxt, pwrite_nxt, penable_nxt;
    logic [DW-1:0]   hrdata_nxt, pwdata_nxt;
    logic [AW-1:0]   paddr_nxt;
    logic [NSLV-1:0] psel_nxt;

    // Decode in AW bits; addresses below BASE wrap to large offsets and miss.
    logic [AW-1:0] off_c;
    logic          hit_c;
    logic [IW-1:0] idx_c;
    assign off_c = haddr - BASE;
    assign hit_c = (off_c < SPAN);
    assign idx_c = IW'(off_c >> RSH);

    logic          pready_c, pslverr_c, expired_c;
    logic [DW-1:0] prdata_c;
    assign pready_c  = pready[sel_q];
    assign pslverr_c = pslverr[sel_q];
    assign prdata_c  = prdata[32'(sel_q)*DW +: DW];

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] acc_cnt;

    // Counts ACCESS-phase cycles that ended without pready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt <= '0;
        end else if (state == ACCESS && penable && !pready_c) begin
            acc_cnt <= acc_cnt + CW'(1);
        end else begin
            acc_cnt <= '0;
        end
    end
    assign expired_c = (acc_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expired_c      = 1'b0;
`endif

    // APB pins are registered, so the bus SETUP phase appears in the first ACCESS-state cycle.
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_q;
        hready_nxt  = hready_out;
        hrdata_nxt  = hrdata;
        hresp_nxt   = hresp;
        paddr_nxt   = paddr;
        pwrite_nxt  = pwrite;
        pwdata_nxt  = pwdata;
        psel_nxt    = psel;
        penable_nxt = penable;
        case (state)
            IDLE: begin
                if (bridge_enable) begin
                    hready_nxt = 1'b0;
                    hresp_nxt  = 1'b0;
                    if (hit_c) begin
                        state_nxt  = SETUP;
                        sel_nxt    = idx_c;
                        paddr_nxt  = off_c & OFF_MASK;
                        pwrite_nxt = hwrite;
                        pwdata_nxt = hwdata;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            SETUP: begin
                psel_nxt  = NSLV'(1) << sel_q;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!penable) begin
                    penable_nxt = 1'b1;
                end else if (pready_c || expired_c) begin
                    state_nxt   = IDLE;
                    hready_nxt  = 1'b1;
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    hresp_nxt   = pready_c ? pslverr_c : 1'b1;
                    if (pready_c && !pwrite) begin
                        hrdata_nxt = prdata_c;
                    end
                end
            end
            ERR: begin
                state_nxt  = IDLE;
                hready_nxt = 1'b1;
                hresp_nxt  = 1'b1;
            end
            default: begin
                state_nxt  = IDLE;
                hready_nxt = 1'b1;
                psel_nxt   = '0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            hready_out <= 1'b1;
            hrdata     <= '0;
            hresp      <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            psel       <= '0;
            penable    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel_q      <= sel_nxt;
            hready_out <= hready_nxt;
            hrdata     <= hrdata_nxt;
            hresp      <= hresp_nxt;
            paddr      <= paddr_nxt;
            pwrite     <= pwrite_nxt;
            pwdata     <= pwdata_nxt;
            psel       <= psel_nxt;
            penable    <= penable_nxt;
        end
    end

endmodule
